inv_sqrt_pipe: RTL and testbench
================================

// Module: inv_sqrt_pipe
// PURPOSE
//  Pipelined IEEE-754 single-precision fast inverse square root, y ~= 1/sqrt(x).
//  Magic-constant seed plus one Newton-Raphson step.
//  Accepts one sample per enabled clock.
//  Sits in a streaming datapath and feeds downstream float consumers.
// PARAMETERS
//  MAGIC  32'h5F3759DF  seed constant: y0_bits = MAGIC - (x_bits >> 1)
// PORTS
//  clk        in   1   system clock, all logic on rising edge
//  rst        in   1   synchronous, active-high reset
//  ce         in   1   clock enable; 0 freezes the whole pipeline
//  DataIn     in   32  float32 operand x, sampled on every edge with ce=1
//  DataOut    out  32  float32 result y1
//  DataValid  out  1   DataOut holds a result of a sampled input
// BEHAVIOUR
//  - Reset (rst=1 at edge, priority over ce):
//    - all pipeline registers cleared; DataOut=0, DataValid=0.
//  - Every edge with ce=1 and rst=0:
//    - DataIn enters the pipe as a valid sample; there is no input-valid port.
//    - All stages advance.
//  - Edge with ce=0: every register holds, including DataOut and DataValid.
//    No sample is taken or lost.
//  - Stages; each stage is one register, each multiply is fully in one stage:
//    S1: y0 = MAGIC - (x>>1) as integer bits; xh = 0.5*x (exponent-1); x-path registered
//    S2: q = y0*y0
//    S3: t = xh*q
//    S4: s = 1.5 - t
//    S5: DataOut = y0*s
//  - Latency: input sampled at enabled edge k appears on DataOut after enabled edge k+4.
//    That is 5 enabled edges inclusive.
//  - Throughput: 1 result per enabled edge.
//  - DataValid: 5-bit valid shift register, shifted only when ce=1.
//    Goes high on the 5th enabled edge after reset and stays high.
//  - Float arithmetic:
//    - normal operands only; denormal inputs/intermediates flush to +0.
//    - products and difference rounded to nearest-even.
//    - y0, xh and the delayed x-path are delay-matched through the stages.
//  - Accuracy: DataOut within 2 ULP (bit pattern difference <= 2) of C float model:
//      i=0x5F3759DF-(i>>1); y=y*(1.5f-0.5f*x*y*y)
//  - Special inputs, decided at S1, carried as a flag, forced at S5:
//    - +0/-0/denormal -> 0x7F800000 (+inf)
//    - sign=1 (nonzero) -> 0x7FC00000 (qNaN)
//    - +inf -> 0x00000000
//    - NaN -> 0x7FC00000
//  - Reset asserted mid-stream discards all in-flight samples.
//    First result after release follows the latency rule.
// CONFIGURATION
//  INVSQRT_SECOND_ITER_EN defined:
//    - adds a second Newton step (y1^2, xh*y1^2, 1.5-, y1*s) as 4 more stages.
//    - latency becomes 9 enabled edges; valid shift register is 9 bits.
//    - accuracy target is <= 2 ULP of the C model with two iterations.
//  Undefined: single iteration, latency 5, as above.
// TESTING
//  - Reset: rst=1 for 3 edges -> DataOut=0, DataValid=0.
//    After release with ce=1, DataValid rises exactly on the 5th edge.
//  - x=0x3F800000 (1.0) -> DataOut ~0x3F7F913E (~0.99831), within 2 ULP of C model.
//  - x=0x40800000 (4.0) -> DataOut ~0x3EFF913E (~0.49915), same mantissa as the 1.0 case.
//  - 1000 random positive normal floats, one per edge, ce toggling 60 cycles high / 60 low:
//    - logging DataOut when DataValid&&ce yields 1000 results in input order.
//    - each result within 2 ULP of the C model.
//  - Specials: 0x00000000 -> 0x7F800000; 0xBF800000 -> 0x7FC00000;
//    0x7F800000 -> 0x00000000; 0x7FC00001 -> 0x7FC00000.
//  - ce=0 for 7 cycles mid-stream: DataOut/DataValid constant throughout.
//    No sample dropped or duplicated after ce returns to 1.

Source files
------------

// File: rtl/inv_sqrt_pipe.sv
// Pipelined float32 fast inverse square root: magic-constant seed and Newton-Raphson refinement.
// Define INVSQRT_SECOND_ITER_EN to add a second Newton step (latency 9 instead of 5).
module inv_sqrt_pipe #(
    parameter logic [31:0] MAGIC = 32'h5F3759DF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    input  logic [31:0] DataIn,
    output logic [31:0] DataOut,
    output logic        DataValid
);

`ifdef INVSQRT_SECOND_ITER_EN
    localparam int STAGES = 9;
    localparam int XH_D   = 6;
`else
    localparam int STAGES = 5;
    localparam int XH_D   = 2;
`endif
    localparam logic [31:0] ONE_P5 = 32'h3FC00000;

    // special-case codes carried alongside the sample
    localparam logic [1:0] SP_NONE = 2'd0;
    localparam logic [1:0] SP_INF  = 2'd1;
    localparam logic [1:0] SP_NAN  = 2'd2;
    localparam logic [1:0] SP_ZERO = 2'd3;

    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic [47:0]       p;
        logic signed [9:0] e;
        logic [22:0]       m;
        logic              g;
        logic              st;
        logic [23:0]       mr;
        p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
        e = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd127;
        if (p[47]) begin
            m  = p[46:24];
            g  = p[23];
            st = |p[22:0];
            e  = e + 10'sd1;
        end else begin
            m  = p[45:23];
            g  = p[22];
            st = |p[21:0];
        end
        mr = {1'b0, m} + {23'd0, g & (st | m[0])};
        if (mr[23])
            e = e + 10'sd1;
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0 || e <= 0)
            fmul = 32'h0;
        else if (e >= 255)
            fmul = {a[31] ^ b[31], 8'hFF, 23'd0};
        else
            fmul = {a[31] ^ b[31], e[7:0], mr[22:0]};
    endfunction

    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        logic [31:0]       big;
        logic [31:0]       sml;
        logic [7:0]        d;
        logic [26:0]       mb;
        logic [26:0]       ms;
        logic [26:0]       msh;
        logic [26:0]       r;
        logic [27:0]       sum;
        logic signed [9:0] e;
        logic [4:0]        lz;
        logic [23:0]       mr;
        fadd = 32'h0;
        if (a[30:23] == 8'd0 && b[30:23] == 8'd0) begin
            fadd = 32'h0;
        end else if (a[30:23] == 8'd0) begin
            fadd = b;
        end else if (b[30:23] == 8'd0) begin
            fadd = a;
        end else begin
            if (a[30:0] >= b[30:0]) begin
                big = a;
                sml = b;
            end else begin
                big = b;
                sml = a;
            end
            d  = big[30:23] - sml[30:23];
            mb = {1'b1, big[22:0], 3'b000};
            ms = {1'b1, sml[22:0], 3'b000};
            if (d > 8'd26) begin
                msh = 27'd1;
            end else begin
                msh    = ms >> d;
                msh[0] = msh[0] | (|(ms & ~(27'h7FFFFFF << d)));
            end
            e = $signed({2'b00, big[30:23]});
            if (big[31] == sml[31]) begin
                sum = {1'b0, mb} + {1'b0, msh};
                if (sum[27]) begin
                    sum = {1'b0, sum[27:2], sum[1] | sum[0]};
                    e   = e + 10'sd1;
                end
                r = sum[26:0];
            end else begin
                r  = mb - msh;
                lz = 5'd0;
                for (int i = 0; i < 27; i++)
                    if (r[i]) lz = 5'(26 - i);
                r = r << lz;
                e = e - $signed({5'b00000, lz});
            end
            // guard / round / sticky live in the three low bits
            mr = {1'b0, r[25:3]} + {23'd0, r[2] & (r[1] | r[0] | r[3])};
            if (mr[23])
                e = e + 10'sd1;
            if (r == 27'd0 || e <= 0)
                fadd = 32'h0;
            else if (e >= 255)
                fadd = {big[31], 8'hFF, 23'd0};
            else
                fadd = {big[31], e[7:0], mr[22:0]};
        end
    endfunction

    function automatic logic [31:0] fhalf(input logic [31:0] x);
        if (x[30:23] <= 8'd1)
            fhalf = 32'h0;
        else
            fhalf = {x[31], x[30:23] - 8'd1, x[22:0]};
    endfunction

    function automatic logic [31:0] force_spec(input logic [1:0] code, input logic [31:0] v);
        case (code)
            SP_INF:  force_spec = 32'h7F800000;
            SP_NAN:  force_spec = 32'h7FC00000;
            SP_ZERO: force_spec = 32'h00000000;
            default: force_spec = v;
        endcase
    endfunction

    logic [31:0]       y0_d   [1:4];
    logic [31:0]       xh_d   [1:XH_D];
    logic [1:0]        spec_d [1:STAGES-1];
    logic [31:0]       q_2;
    logic [31:0]       t_3;
    logic [31:0]       s_4;
    logic [31:0]       y1;
    logic [1:0]        spec_in;
    logic [STAGES-1:0] vld_sr;
`ifdef INVSQRT_SECOND_ITER_EN
    logic [31:0]       y1_5, y1_6, y1_7, y1_8;
    logic [31:0]       q_6, t_7, s_8;
`endif

    always_comb begin
        spec_in = SP_NONE;
        if (DataIn[30:23] == 8'd0)
            spec_in = SP_INF;
        else if (DataIn[30:23] == 8'hFF && DataIn[22:0] != 23'd0)
            spec_in = SP_NAN;
        else if (DataIn[31])
            spec_in = SP_NAN;
        else if (DataIn[30:23] == 8'hFF)
            spec_in = SP_ZERO;
    end

    assign y1 = fmul(y0_d[4], s_4);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i <= 4; i++) y0_d[i] <= '0;
            for (int i = 1; i <= XH_D; i++) xh_d[i] <= '0;
            for (int i = 1; i <= STAGES - 1; i++) spec_d[i] <= SP_NONE;
            q_2       <= '0;
            t_3       <= '0;
            s_4       <= '0;
            vld_sr    <= '0;
            DataOut   <= '0;
`ifdef INVSQRT_SECOND_ITER_EN
            y1_5 <= '0; y1_6 <= '0; y1_7 <= '0; y1_8 <= '0;
            q_6  <= '0; t_7  <= '0; s_8  <= '0;
`endif
        end else if (ce) begin
            y0_d[1] <= MAGIC - {1'b0, DataIn[31:1]};
            for (int i = 2; i <= 4; i++) y0_d[i] <= y0_d[i-1];
            xh_d[1] <= fhalf(DataIn);
            for (int i = 2; i <= XH_D; i++) xh_d[i] <= xh_d[i-1];
            spec_d[1] <= spec_in;
            for (int i = 2; i <= STAGES - 1; i++) spec_d[i] <= spec_d[i-1];
            q_2    <= fmul(y0_d[1], y0_d[1]);
            t_3    <= fmul(xh_d[2], q_2);
            s_4    <= fadd(ONE_P5, {~t_3[31], t_3[30:0]});
            vld_sr <= {vld_sr[STAGES-2:0], 1'b1};
`ifdef INVSQRT_SECOND_ITER_EN
            y1_5    <= y1;
            q_6     <= fmul(y1_5, y1_5);
            y1_6    <= y1_5;
            t_7     <= fmul(xh_d[6], q_6);
            y1_7    <= y1_6;
            s_8     <= fadd(ONE_P5, {~t_7[31], t_7[30:0]});
            y1_8    <= y1_7;
            DataOut <= force_spec(spec_d[8], fmul(y1_8, s_8));
`else
            DataOut <= force_spec(spec_d[4], y1);
`endif
        end
    end

    assign DataValid = vld_sr[STAGES-1];

endmodule

// File: tb/tb_inv_sqrt_pipe.sv
// Directed and random bench for inv_sqrt_pipe; the reference rounds every float op from exact doubles.
module tb_inv_sqrt_pipe;
`ifdef INVSQRT_SECOND_ITER_EN
    localparam int LAT = 9;
    localparam int NIT = 2;
`else
    localparam int LAT = 5;
    localparam int NIT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ce = 1'b0;
    logic [31:0] DataIn = 32'h0;
    logic [31:0] DataOut;
    logic        DataValid;

    inv_sqrt_pipe dut (
        .clk(clk),
        .rst(rst),
        .ce(ce),
        .DataIn(DataIn),
        .DataOut(DataOut),
        .DataValid(DataValid)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] expv;
        int unsigned tol;
    } exp_t;

    exp_t        exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_rand = 0;
    logic [31:0] last_exp = 32'h0;
    logic [31:0] dir_vec [10];

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        logic [31:0] b;
        int          e;
        d = $realtobits(r);
        if (d[62:0] == 63'd0) return 32'h0;
        e = int'(d[62:52]) - 896;
        b = {d[63], e[7:0], d[51:29]};
        if (d[28] && ((|d[27:0]) || d[29])) b = b + 32'd1;
        return b;
    endfunction

    function automatic real f2r(input logic [31:0] f);
        logic [10:0] e11;
        if (f[30:23] == 8'd0) return 0.0;
        e11 = {3'b000, f[30:23]} + 11'd896;
        return $bitstoreal({f[31], e11, f[22:0], 29'd0});
    endfunction

    function automatic real rnd(input real r);
        return f2r(r2f(r));
    endfunction

    function automatic bit is_special(input logic [31:0] x);
        return x[30:23] == 8'd0 || x[30:23] == 8'hFF || x[31];
    endfunction

    // C float model: y = y*(1.5f - ((0.5f*x)*y)*y)
    function automatic logic [31:0] ref_isqrt(input logic [31:0] x);
        real xh, y;
        if (x[30:23] == 8'd0) return 32'h7F800000;
        if (x[30:23] == 8'hFF && x[22:0] != 23'd0) return 32'h7FC00000;
        if (x[31]) return 32'h7FC00000;
        if (x[30:23] == 8'hFF) return 32'h00000000;
        xh = rnd(0.5 * f2r(x));
        y  = f2r(32'h5F3759DF - {1'b0, x[31:1]});
        for (int k = 0; k < NIT; k++)
            y = rnd(y * rnd(1.5 - rnd(rnd(xh * y) * y)));
        return r2f(y);
    endfunction

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv,
                             input int unsigned tol);
        int unsigned diff;
        n_cmp++;
        diff = (obs > expv) ? obs - expv : expv - obs;
        if (diff > tol) begin
            n_bad++;
            $display("FAIL %s: got %08h want %08h (tol %0d)", tag, obs, expv, tol);
        end
    endtask

    task automatic step(input logic ce_v, input logic [31:0] din, input string tag);
        exp_t e;
        ce     = ce_v;
        DataIn = din;
        @(posedge clk);
        #1;
        if (rst) begin
            exp_q.delete();
        end else if (ce_v) begin
            e.tag  = $sformatf("%s_%08h", tag, din);
            e.expv = ref_isqrt(din);
            e.tol  = is_special(din) ? 0 : 2;
            exp_q.push_back(e);
            if (DataValid) begin
                e = exp_q.pop_front();
                check_val(e.tag, DataOut, e.expv, e.tol);
                last_exp = e.expv;
                if (e.tag.substr(0, 3) == "rand") n_rand++;
            end
        end
    endtask

    function automatic logic [31:0] rand_pos_normal();
        logic [7:0]  ex;
        logic [22:0] mt;
        ex = 8'($urandom_range(230, 20));
        mt = 23'($urandom);
        return {1'b0, ex, mt};
    endfunction

    initial begin
        int sent;
        int c;
        dir_vec = '{32'h3F800000, 32'h40800000, 32'h40000000, 32'h3E800000, 32'h00000000,
                    32'hBF800000, 32'h7F800000, 32'h7FC00001, 32'h80000000, 32'h00000001};

        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 32'h3F800000, "rst");
            check_val("rst_out", DataOut, 32'h0, 0);
            check_val("rst_vld", {31'd0, DataValid}, 32'd0, 0);
        end
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            step(1'b1, dir_vec[i], "dir");
            if (i < LAT) check_val("vld_rise", {31'd0, DataValid}, {31'd0, i == LAT - 1}, 0);
        end

        step(1'b1, 32'h42C80000, "hold");
        step(1'b1, 32'h3C23D70A, "hold");
        step(1'b1, 32'h49742400, "hold");
        for (int i = 0; i < 7; i++) begin
            step(1'b0, 32'hDEADBEEF, "frozen");
            check_val("hold_out", DataOut, last_exp, 2);
            check_val("hold_vld", {31'd0, DataValid}, 32'd1, 0);
        end
        for (int i = 0; i < 6; i++) step(1'b1, 32'h40400000 + 32'(i << 20), "after_hold");

        step(1'b1, 32'h41200000, "pre_rst");
        step(1'b1, 32'h3F000000, "pre_rst");
        rst = 1'b1;
        step(1'b1, 32'h3F800000, "mid_rst");
        check_val("mid_rst_out", DataOut, 32'h0, 0);
        check_val("mid_rst_vld", {31'd0, DataValid}, 32'd0, 0);
        rst = 1'b0;
        for (int i = 0; i < LAT; i++) begin
            step(1'b1, 32'h40C00000 + 32'(i << 18), "post_rst");
            check_val("post_rst_vld", {31'd0, DataValid}, {31'd0, i == LAT - 1}, 0);
        end

        sent = 0;
        c    = 0;
        while (sent < 1000) begin
            if (((c / 60) % 2) == 0) begin
                step(1'b1, rand_pos_normal(), "rand");
                sent++;
            end else begin
                step(1'b0, $urandom, "idle");
            end
            c++;
        end
        for (int i = 0; i < LAT; i++) step(1'b1, 32'h3F800000, "drain");
        check_val("rand_count", 32'(n_rand), 32'd1000, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
